// File: rtl/des_pkg.sv
// Shared DES permutation tables, FSM state encoding and block widths for the
// inverse-initial-permutation output stage.
package des_pkg;

  localparam int DES_BLK_W  = 64;
  localparam int DES_HALF_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    PERM,
    DONE
  } des_state_e;

  // Element [1] is the leftmost entry; each entry names the 1-based source bit.
  localparam logic [1:64][6:0] FP_TAB = {
    7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  localparam logic [1:64][6:0] IP_TAB = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

endpackage

// File: rtl/des_perm64.sv
// Combinational 64-bit table permutation: dout[i] = din[TAB[i]], with TAB
// selected between the final (FP) and initial (IP) DES permutations.
module des_perm64
  import des_pkg::*;
#(
  parameter bit USE_IP = 1'b0
) (
  input  logic [1:DES_BLK_W] din,
  output logic [1:DES_BLK_W] dout
);

  for (genvar i = 1; i <= DES_BLK_W; i++) begin : g_bit
    localparam int SRC = USE_IP ? int'(IP_TAB[i]) : int'(FP_TAB[i]);
    assign dout[i] = din[SRC];
  end

endmodule

// File: rtl/ip_inv_swap.sv
// DES output stage: captures the round-16 halves, applies IP^-1 and hands the
// result out with a start/ready level handshake. Optional self-check of the
// result by re-applying IP is enabled with macro IP_INV_SELFCHECK_EN.
module ip_inv_swap
  import des_pkg::*;
#(
  parameter int PRESWAP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:DES_HALF_W]  l_in,
  input  logic [1:DES_HALF_W]  r_in,
  output logic [1:DES_BLK_W]   desOut,
  output logic                 ready,
  output logic                 busy,
  output logic                 chk_err
);

  des_state_e state, state_nxt;
  logic                start_dly;
  logic                armed;
  logic                launch;
  logic [1:DES_BLK_W]  cap;
  logic [1:DES_BLK_W]  cap_nxt;
  logic [1:DES_BLK_W]  fp_out;

  assign cap_nxt = (PRESWAP != 0) ? {r_in, l_in} : {l_in, r_in};

  // armed blocks a launch from a start level that was already high when reset
  // released; it needs one sampled low before the next rising edge counts.
  assign launch = (state == IDLE) && start && !start_dly && armed;

  des_perm64 #(.USE_IP(1'b0)) u_fp (
    .din  (cap),
    .dout (fp_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = CAPT;
      CAPT:    state_nxt = PERM;
      PERM:    state_nxt = start ? DONE : IDLE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_dly <= 1'b0;
      armed     <= 1'b0;
      cap       <= '0;
      desOut    <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      start_dly <= start;
      if (!start)      armed <= 1'b1;
      else if (launch) armed <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            cap  <= cap_nxt;
            busy <= 1'b1;
          end
        end
        PERM: begin
          // The result register updates even on abort; only ready is withheld.
          desOut <= fp_out;
          busy   <= 1'b0;
          ready  <= start;
        end
        DONE: begin
          if (!start) ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef IP_INV_SELFCHECK_EN
  logic [1:DES_BLK_W] ip_chk;
  logic               chk_q;

  des_perm64 #(.USE_IP(1'b1)) u_ip (
    .din  (desOut),
    .dout (ip_chk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              chk_q <= 1'b0;
    else if (launch)                         chk_q <= 1'b0;
    else if (state == DONE && ip_chk != cap) chk_q <= 1'b1;
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ip_inv_swap.sv
// Scoreboard bench for ip_inv_swap: two instances (PRESWAP=1 and PRESWAP=0 fed
// with swapped halves) must produce identical known DES output blocks.
module tb_ip_inv_swap;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] l_drv, r_drv;
  logic [1:64] dout0, dout1;
  logic        rdy0, rdy1, bsy0, bsy1, err0, err1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic        prev_rdy = 1'b0;

  always #5 clk = ~clk;

  ip_inv_swap #(.PRESWAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .l_in(l_drv), .r_in(r_drv),
    .desOut(dout0), .ready(rdy0), .busy(bsy0), .chk_err(err0)
  );

  ip_inv_swap #(.PRESWAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .l_in(r_drv), .r_in(l_drv),
    .desOut(dout1), .ready(rdy1), .busy(bsy1), .chk_err(err1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected block each time ready rises.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy_and_ready_u0", {63'b0, rdy0 & bsy0}, 64'd0);
      if (rdy0 && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 64'd1, 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          chk("desOut_u0", dout0, exp_v);
          chk("desOut_u1", dout1, exp_v);
          chk("ready_u1", {63'b0, rdy1}, 64'd1);
        end
      end
    end
    prev_rdy <= rdy0;
  end

  // Called at a negedge; returns at the negedge after the third active edge.
  task automatic run_vec(input logic [31:0] l, input logic [31:0] r, input logic [63:0] exp);
    l_drv = l;
    r_drv = r;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("capt_busy",  {63'b0, bsy0}, 64'd1);
    chk("capt_ready", {63'b0, rdy0}, 64'd0);
    @(negedge clk);
    chk("perm_busy",  {63'b0, bsy0}, 64'd1);
    chk("perm_ready", {63'b0, rdy0}, 64'd0);
    @(negedge clk);
    chk("done_ready", {63'b0, rdy0}, 64'd1);
    chk("done_busy",  {63'b0, bsy0}, 64'd0);
    chk("done_busy_u1", {63'b0, bsy1}, 64'd0);
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(negedge clk);
    chk("drop_ready_u0", {63'b0, rdy0}, 64'd0);
    chk("drop_ready_u1", {63'b0, rdy1}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [1:64] tmp;
    rst_n = 1'b0;
    start = 1'b0;
    l_drv = '0;
    r_drv = '0;
    repeat (2) @(negedge clk);
    chk("rst_desOut", dout0, 64'd0);
    chk("rst_ready",  {63'b0, rdy0}, 64'd0);
    chk("rst_busy",   {63'b0, bsy0}, 64'd0);
    chk("rst_chk_err", {63'b0, err0}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known DES example, held in DONE, inputs wiggled, then released.
    run_vec(32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405);
    l_drv = 32'hFFFF0000;
    r_drv = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("hold_desOut", dout0, 64'h85E813540F0AB405);
    chk("hold_ready",  {63'b0, rdy0}, 64'd1);
    drop_start();
    chk("idle_desOut", dout0, 64'h85E813540F0AB405);

    // Abort: start falls while in CAPT.
    l_drv = 32'hFFFFFFFF;
    r_drv = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_perm", {63'b0, bsy0}, 64'd1);
    @(negedge clk);
    chk("abort_busy",   {63'b0, bsy0}, 64'd0);
    chk("abort_ready",  {63'b0, rdy0}, 64'd0);
    chk("abort_desOut", dout0, 64'hFFFFFFFFFFFFFFFF);
    chk("abort_state",  64'(u0.state), 64'(des_pkg::IDLE));
    repeat (2) @(negedge clk);
    run_vec(32'h0, 32'h0, 64'h0);
    drop_start();

    // Textbook IP^-1 vector; u0 swaps, so halves are presented pre-swapped.
    run_vec(32'hF0AAF0AA, 32'hCC00CCFF, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("vecB_chk_err", {63'b0, err0}, 64'd0);
    drop_start();

    // Reset in PERM, then start held high across reset release.
    l_drv = 32'h12345678;
    r_drv = 32'h9ABCDEF0;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {63'b0, bsy0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_desOut", dout0, 64'd0);
    chk("arst_ready",  {63'b0, rdy0}, 64'd0);
    chk("arst_busy",   {63'b0, bsy0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy",  {63'b0, bsy0}, 64'd0);
    chk("post_rst_state", 64'(u0.state), 64'(des_pkg::IDLE));
    chk("post_rst_desOut", dout0, 64'd0);
    start = 1'b0;
    @(negedge clk);
    run_vec(32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405);
    drop_start();

`ifdef IP_INV_SELFCHECK_EN
    run_vec(32'hF0AAF0AA, 32'hCC00CCFF, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("sc_clean", {63'b0, err0}, 64'd0);
    tmp = u0.cap;
    force u0.cap = tmp ^ 64'h1;
    @(negedge clk);
    release u0.cap;
    @(negedge clk);
    chk("sc_err_set", {63'b0, err0}, 64'd1);
    chk("sc_u1_clean", {63'b0, err1}, 64'd0);
    drop_start();
    chk("sc_err_sticky", {63'b0, err0}, 64'd1);
    run_vec(32'h0, 32'h0, 64'h0);
    chk("sc_err_cleared", {63'b0, err0}, 64'd0);
    @(negedge clk);
    chk("sc_err_stays_clear", {63'b0, err0}, 64'd0);
    drop_start();
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
